// File: rtl/qwi12_petaled_pkg.sv
// Shared types and the triangle-duty helper for the four-LED petal breathing controller.
package qwi12_petaled_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } petal_state_t;

    // A position on the 2^(pwm_w+1) phase circle maps to a rising ramp, then a falling ramp.
    function automatic int unsigned tri_duty(input int unsigned pos, input int unsigned pwm_w);
        int unsigned half;
        half = 32'd1 << pwm_w;
        if (pos < half)
            return pos;
        return (2 * half) - 1 - pos;
    endfunction

endpackage

// File: rtl/qwi12_pwm_timebase.sv
// Prescaler, PWM counter and phase divider; a synchronous clr holds everything at zero.
module qwi12_pwm_timebase #(
    parameter int PWM_W    = 8,
    parameter int PRESCALE = 390,
    parameter int RAMP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             tick,
    output logic             period_end,
    output logic             phase_step,
    output logic [PWM_W-1:0] pwm_cnt
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RAMP_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [DIV_W-1:0] div_cnt;

    // Events are suppressed while cleared so a PRESCALE of 1 cannot fire from the held state.
    assign tick       = ~clr & (pre_cnt == PRE_MAX);
    assign period_end = tick & (&pwm_cnt);
    assign phase_step = period_end & (div_cnt == DIV_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            div_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end)
                div_cnt <= phase_step ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qwi12_led_petal.sv
// Petal breathing controller: LEDs breathe with rotated triangle duties and drain to dark on disable.
module qwi12_led_petal
    import qwi12_petaled_pkg::*;
#(
    parameter int LED_N    = 4,
    parameter int PWM_W    = 8,
    parameter int PRESCALE = 390,
    parameter int RAMP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [LED_N-1:0] led,
    output logic             busy,
    output petal_state_t     dbg_state
);

    localparam int PH_W = PWM_W + 1;
    localparam int OFFS = (1 << PH_W) / LED_N;

    logic             en_q;
    petal_state_t     state, state_nx;
    logic [LED_N-1:0] off, off_nx;
    logic [PH_W-1:0]  phase;
    logic [LED_N-1:0] zero_duty, lit;
    logic             clr, tick_unused, period_end, phase_step;
    logic [PWM_W-1:0] pwm_cnt;

    qwi12_pwm_timebase #(
        .PWM_W   (PWM_W),
        .PRESCALE(PRESCALE),
        .RAMP_DIV(RAMP_DIV)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .tick      (tick_unused),
        .period_end(period_end),
        .phase_step(phase_step),
        .pwm_cnt   (pwm_cnt)
    );

    for (genvar i = 0; i < LED_N; i++) begin : g_led
        logic [PH_W-1:0]  pos;
        logic [PWM_W-1:0] duty;
        assign pos          = phase + PH_W'(i * OFFS);
        assign duty         = PWM_W'(tri_duty(32'(pos), PWM_W));
        assign zero_duty[i] = (duty == '0);
        assign lit[i]       = (pwm_cnt < duty);
    end

    // Re-enable wins over completing the drain; the phase is untouched so breathing resumes smoothly.
    always_comb begin
        state_nx = state;
        off_nx   = off;
        case (state)
            IDLE: begin
                if (en_q) begin
                    state_nx = RUN;
                    off_nx   = '0;
                end else begin
                    off_nx   = '1;
                end
            end
            RUN: begin
                off_nx = '0;
                if (!en_q)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (en_q) begin
                    state_nx = RUN;
                    off_nx   = '0;
                end else if (&off) begin
                    state_nx = IDLE;
                    off_nx   = '1;
                end else if (period_end) begin
                    off_nx   = off | zero_duty;
                end
            end
            default: begin
                state_nx = IDLE;
                off_nx   = '1;
            end
        endcase
    end

    assign clr       = (state == IDLE) | (state_nx == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q  <= 1'b0;
            state <= IDLE;
            off   <= '1;
            phase <= '0;
            led   <= '0;
        end else begin
            en_q  <= en;
            state <= state_nx;
            off   <= off_nx;
            if (clr)
                phase <= '0;
            else if (phase_step)
                phase <= phase + 1'b1;
            led   <= {LED_N{state != IDLE}} & ~off & lit;
        end
    end

endmodule

// File: tb/tb_qwi12_led_petal.sv
// Scoreboard bench for qwi12_led_petal: an elapsed-time reference model predicts state, busy and led each cycle.
module tb_qwi12_led_petal;
    import qwi12_petaled_pkg::*;

    localparam int LED_N    = 4;
    localparam int PWM_W    = 4;
    localparam int PRESCALE = 2;
    localparam int RAMP_DIV = 1;
    localparam int PH_MOD   = 1 << (PWM_W + 1);
    localparam int PWM_MOD  = 1 << PWM_W;
    localparam int PERIOD   = PRESCALE * PWM_MOD;
    localparam int SW       = 2 + 1 + LED_N;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [LED_N-1:0] led;
    logic             busy;
    petal_state_t     dbg_state;

    qwi12_led_petal #(
        .LED_N   (LED_N),
        .PWM_W   (PWM_W),
        .PRESCALE(PRESCALE),
        .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .led      (led),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    logic [SW-1:0] exp_q[$];

    // reference model: counters are derived from cycles elapsed since RUN was entered
    logic             m_en_q = 1'b0;
    int               m_st   = 0;
    int               m_e    = 0;
    logic [LED_N-1:0] m_off  = '1;

    function automatic int m_phase(input int e);
        return (e / PERIOD / RAMP_DIV) % PH_MOD;
    endfunction

    function automatic int m_pwm(input int e);
        return (e / PRESCALE) % PWM_MOD;
    endfunction

    function automatic int m_duty(input int i, input int e);
        int pos;
        pos = (m_phase(e) + i * (PH_MOD / LED_N)) % PH_MOD;
        return (pos < PWM_MOD) ? pos : PH_MOD - 1 - pos;
    endfunction

    task automatic model_step();
        int nst;
        logic [LED_N-1:0] noff, nled;
        bit pend;
        pend = ((m_e % PRESCALE) == PRESCALE - 1) && (m_pwm(m_e) == PWM_MOD - 1);
        for (int i = 0; i < LED_N; i++)
            nled[i] = (m_st != 0) && !m_off[i] && (m_pwm(m_e) < m_duty(i, m_e));
        nst  = m_st;
        noff = m_off;
        if (m_st == 0) begin
            nst  = m_en_q ? 1 : 0;
            noff = m_en_q ? '0 : '1;
        end else if (m_st == 1) begin
            nst  = m_en_q ? 1 : 2;
            noff = '0;
        end else begin
            if (m_en_q) begin
                nst  = 1;
                noff = '0;
            end else if (&m_off) begin
                nst  = 0;
                noff = '1;
            end else if (pend) begin
                for (int i = 0; i < LED_N; i++)
                    if (m_duty(i, m_e) == 0) noff[i] = 1'b1;
            end
        end
        exp_q.push_back({2'(nst), nst != 0, nled});
        m_e    = (m_st == 0 || nst == 0) ? 0 : m_e + 1;
        m_st   = nst;
        m_off  = noff;
        m_en_q = en;
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_en_q = 1'b0;
                m_st   = 0;
                m_e    = 0;
                m_off  = '1;
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    // scoreboard monitor
    initial begin : monitor_proc
        logic [SW-1:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {dbg_state, busy, led};
                checks++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t state/busy/led got %b expected %b", $time, act_v, exp_v);
                end
            end
        end
    end

    // driver tasks
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic set_en(input logic v);
        @(negedge clk);
        en = v;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_led", int'(led), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int k;
        k = 0;
        while (m_phase(m_e) != ph && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_phase", m_phase(m_e), ph);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_done_busy", int'(busy), 0);
        check("drain_done_state", int'(dbg_state), int'(IDLE));
    endtask

    task automatic count_high(input int idx, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (led[idx]) hi++;
        end
    endtask

    initial begin : stim
        int hi0, hi2, k;

        // reset and long idle
        #1 rst = 1'b1;
        #1;
        check("init_led", int'(led), 0);
        check("init_busy", int'(busy), 0);
        cycles(3);
        rst = 1'b0;
        cycles(1000);

        // enable latency, then phase-0 darkness on led[0]
        set_en(1'b1);
        @(negedge clk);
        check("en_latency_t1", int'(busy), 0);
        @(negedge clk);
        check("en_latency_t2", int'(busy), 1);
        count_high(0, PERIOD, hi0);
        check("phase0_led0_high", hi0, 0);

        // phase offset at phase 16
        wait_phase(16, 2000);
        fork
            count_high(0, PERIOD, hi0);
            count_high(2, PERIOD, hi2);
        join
        check("phase16_led0_high", hi0, 15 * PRESCALE);
        check("phase16_led2_high", hi2, 0);

        // drain from phase 10
        wait_phase(10, 2000);
        set_en(1'b0);
        wait_idle(PERIOD * PH_MOD * RAMP_DIV + PERIOD + 8);

        // re-enable after the first LED has drained
        set_en(1'b1);
        cycles($urandom_range(100, 600));
        set_en(1'b0);
        k = 0;
        while (!(m_st == 2 && m_off != '0) && k < 1200) begin
            @(negedge clk);
            k++;
        end
        check("reenable_partial_off", int'(m_st == 2 && m_off != '0 && m_off != '1), 1);
        set_en(1'b1);
        cycles(3);
        check("reenable_state", int'(dbg_state), int'(RUN));
        cycles(200);

        // reset mid-RUN with en held high
        pulse_rst();
        @(negedge clk);
        check("rst_resume_t1", int'(busy), 0);
        @(negedge clk);
        check("rst_resume_t2", int'(busy), 1);

        // randomized enable toggling with occasional resets
        for (int r = 0; r < 10; r++) begin
            set_en(1'($urandom_range(0, 1)));
            cycles($urandom_range(20, 1200));
            if ($urandom_range(0, 4) == 0)
                pulse_rst();
        end
        set_en(1'b0);
        wait_idle(PERIOD * PH_MOD * RAMP_DIV + PERIOD + 8);
        cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
